// File: rtl/cdbus_pkg.sv
// Shared CDBUS receive-path definitions: CRC-16/MODBUS constants, receiver states, CRC step.
// Latency: none (declarations only).
// Backpressure: none.
package cdbus_pkg;

   localparam logic [15:0] CRC16_POLY = 16'hA001;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   typedef enum logic [2:0] {
      WAIT_IDLE = 3'd0,
      HUNT      = 3'd1,
      START     = 3'd2,
      DATA      = 3'd3,
      STOP      = 3'd4
   } rx_state_t;

   // One reflected CRC-16 step for a single serial bit (LSB-first order).
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
      crc16_step = (crc >> 1) ^ ((crc[0] ^ b) ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16/MODBUS register, one data bit per enabled cycle.
// Latency: crc reflects a bit one cycle after en.
// Backpressure: none; clr has priority over en.
module crc16_serial
   import cdbus_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clr,
   input  logic        en,
   input  logic        bit_val,
   output logic [15:0] crc
);

   // Shift one bit into the CRC, or restart the frame CRC on clr.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         crc <= CRC16_INIT;
      end else if (clr) begin
         crc <= CRC16_INIT;
      end else if (en) begin
         crc <= crc16_step(crc, bit_val);
      end
   end

endmodule

// File: rtl/rx_ser.sv
// CDBUS serial receive front end: sync rx, recover 8N1 bytes, running CRC, bus-idle detect.
// Latency: data_clk one cycle after the mid-stop-bit sample; start edge seen 2 clk after rx falls.
// Backpressure: none; data_clk is a one-cycle strobe the consumer must take.
module rx_ser
   import cdbus_pkg::*;
#(
   parameter int DIV_W    = 16,
   parameter int IDLE_LEN = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             rx,
   input  logic [DIV_W-1:0] div_ls,
   input  logic [DIV_W-1:0] div_hs,
   input  logic             wait_bus_idle,
   output logic             bus_idle,
   output logic [7:0]       data,
   output logic [15:0]      crc_data,
   output logic             data_clk,
   output logic             error
);

   localparam int IB_W = $clog2(IDLE_LEN + 1);

   rx_state_t        state;
   logic             rx_s1, rx_s2, rx_prev;
   logic [DIV_W-1:0] phase;
   logic [DIV_W-1:0] idle_cnt;
   logic [IB_W-1:0]  idle_bits;
   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;
   logic [3:0]       byte_idx;
   logic             was_idle;
   logic [15:0]      crc_shadow;

   logic             fall;
   logic             abort;
   logic             idle_run;
   logic             idle_expire;
   logic             frame_init;
   logic             crc_en;
   logic [DIV_W-1:0] rate_div;

   // Arbitration byte at the low rate, the rest of the frame at the high rate.
   assign rate_div    = (byte_idx == 4'd0) ? div_ls : div_hs;
   assign fall        = rx_prev & ~rx_s2;
   // A wait request while already idle has nothing to abandon.
   assign abort       = wait_bus_idle & ~bus_idle;
   // Idle timing runs while waiting for idle, or between bytes of a live frame.
   assign idle_run    = (state == WAIT_IDLE) || ((state == HUNT) && !bus_idle);
   assign idle_expire = idle_run && rx_s2 && (idle_cnt >= div_ls)
                        && (idle_bits == IB_W'(IDLE_LEN - 1));
   assign frame_init  = idle_expire & ~abort;
   assign crc_en      = (state == DATA) && (phase == '0) && !abort;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // Count full low-rate bit periods of continuous rx high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt  <= '0;
         idle_bits <= '0;
      end else if (abort || !idle_run || !rx_s2 || idle_expire) begin
         idle_cnt  <= '0;
         idle_bits <= '0;
      end else if (idle_cnt >= div_ls) begin
         idle_cnt  <= '0;
         idle_bits <= idle_bits + 1'b1;
      end else begin
         idle_cnt  <= idle_cnt + 1'b1;
      end
   end

   crc16_serial u_crc (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (frame_init),
      .en      (crc_en),
      .bit_val (rx_s2),
      .crc     (crc_shadow)
   );

   // Receiver FSM with registered byte, CRC, idle and strobe outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= WAIT_IDLE;
         bus_idle <= 1'b0;
         data     <= 8'h00;
         crc_data <= CRC16_INIT;
         data_clk <= 1'b0;
         error    <= 1'b0;
         phase    <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         byte_idx <= '0;
         was_idle <= 1'b0;
      end else begin
         data_clk <= 1'b0;
         error    <= 1'b0;
         if (abort) begin
            // Abandon any partial byte; only a fresh idle period re-arms the receiver.
            state   <= WAIT_IDLE;
            bit_cnt <= '0;
         end else if (idle_expire) begin
            bus_idle <= 1'b1;
            crc_data <= CRC16_INIT;
            byte_idx <= '0;
            state    <= HUNT;
         end else begin
            case (state)
               WAIT_IDLE: begin
                  state <= WAIT_IDLE;
               end
               HUNT: begin
                  if (fall) begin
                     was_idle <= bus_idle;
                     bus_idle <= 1'b0;
                     phase    <= rate_div >> 1;
                     state    <= START;
                  end
               end
               START: begin
                  if (phase == '0) begin
                     if (!rx_s2) begin
                        phase   <= rate_div;
                        bit_cnt <= '0;
                        state   <= DATA;
                     end else begin
                        // Glitch: a short low pulse must not end an idle period.
                        bus_idle <= was_idle;
                        state    <= HUNT;
                     end
                  end else begin
                     phase <= phase - 1'b1;
                  end
               end
               DATA: begin
                  if (phase == '0) begin
                     shreg <= {rx_s2, shreg[7:1]};
                     phase <= rate_div;
                     if (bit_cnt == 3'd7) begin
                        state <= STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end else begin
                     phase <= phase - 1'b1;
                  end
               end
               STOP: begin
                  if (phase == '0) begin
                     if (rx_s2) begin
                        data_clk <= 1'b1;
                        data     <= shreg;
                        crc_data <= crc_shadow;
                        if (byte_idx != 4'hF) begin
                           byte_idx <= byte_idx + 4'd1;
                        end
                        state <= HUNT;
                     end else begin
                        error <= 1'b1;
                        state <= WAIT_IDLE;
                     end
                  end else begin
                     phase <= phase - 1'b1;
                  end
               end
               default: state <= WAIT_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rx_ser.sv
// Directed bench for rx_ser: idle timing, byte recovery at both rates, CRC, errors, glitches, wait.
// Latency: expected strobe cycles are hand-derived from the divisor values below.
// Backpressure: none.
module tb_rx_ser;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        rx;
   logic [15:0] div_ls;
   logic [15:0] div_hs;
   logic        wait_bus_idle;
   logic        bus_idle;
   logic [7:0]  data;
   logic [15:0] crc_data;
   logic        data_clk;
   logic        error;

   int n_pass  = 0;
   int n_total = 0;

   int          cyc = 0;
   logic [7:0]  dq[$];
   logic [15:0] cq[$];
   int          dcyc[$];
   int          tx_cyc[$];
   int          err_cnt = 0;
   int          idle_fall_cyc = -1;
   logic        idle_prev = 1'b0;

   rx_ser dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .rx            (rx),
      .div_ls        (div_ls),
      .div_hs        (div_hs),
      .wait_bus_idle (wait_bus_idle),
      .bus_idle      (bus_idle),
      .data          (data),
      .crc_data      (crc_data),
      .data_clk      (data_clk),
      .error         (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every strobe, error pulse and bus_idle falling edge.
   always @(negedge clk) begin
      if (data_clk) begin
         dq.push_back(data);
         cq.push_back(crc_data);
         dcyc.push_back(cyc);
      end
      if (error) err_cnt++;
      if (idle_prev && !bus_idle) idle_fall_cyc = cyc;
      idle_prev = bus_idle;
   end

   // 8N1 byte, L clk per bit; starts and ends on a falling clock edge.
   task automatic send_byte(input logic [7:0] b, input int L, input logic stop_val);
      tx_cyc.push_back(cyc);
      rx = 1'b0;
      repeat (L) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (L) @(negedge clk);
      end
      rx = stop_val;
      repeat (L) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (!bus_idle && k < 400) begin
         @(negedge clk);
         k++;
      end
      n_total++;
      if (bus_idle !== 1'b1) $display("FAIL %s: bus_idle=%b after %0d clk, required 1", name, bus_idle, k);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      n_total++; if (bus_idle !== 1'b0) $display("FAIL reset_bus_idle: got %b want 0", bus_idle); else n_pass++;
      n_total++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else n_pass++;
      n_total++; if (crc_data !== 16'hFFFF) $display("FAIL reset_crc: got %h want ffff", crc_data); else n_pass++;
      n_total++; if (data_clk !== 1'b0) $display("FAIL reset_data_clk: got %b want 0", data_clk); else n_pass++;
      n_total++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else n_pass++;
      reset_n = 1'b1;
      repeat (99) @(negedge clk);
      n_total++; if (bus_idle !== 1'b0) $display("FAIL idle_early: bus_idle=%b at 99 clk, want 0", bus_idle); else n_pass++;
      @(negedge clk);
      n_total++; if (bus_idle !== 1'b1) $display("FAIL idle_at_100: bus_idle=%b at 100 clk, want 1", bus_idle); else n_pass++;
      n_total++; if (dq.size() !== 0) $display("FAIL idle_no_strobe: %0d strobes, want 0", dq.size()); else n_pass++;
   endtask

   task automatic test_two_bytes();
      int n0, t0;
      n0 = dq.size();
      t0 = tx_cyc.size();
      send_byte(8'h55, 10, 1'b1);
      send_byte(8'hA3, 4, 1'b1);
      repeat (5) @(negedge clk);
      n_total++;
      if (dq.size() - n0 !== 2) $display("FAIL two_count: %0d strobes, want 2", dq.size() - n0);
      else begin
         n_pass++;
         n_total++; if (dq[n0] !== 8'h55) $display("FAIL two_byte0: got %h want 55", dq[n0]); else n_pass++;
         n_total++; if (dq[n0+1] !== 8'hA3) $display("FAIL two_byte1: got %h want a3", dq[n0+1]); else n_pass++;
         n_total++; if (dcyc[n0] - tx_cyc[t0] !== 98) $display("FAIL ls_latency: got %0d want 98", dcyc[n0] - tx_cyc[t0]); else n_pass++;
         n_total++; if (dcyc[n0+1] - tx_cyc[t0+1] !== 41) $display("FAIL hs_latency: got %0d want 41", dcyc[n0+1] - tx_cyc[t0+1]); else n_pass++;
      end
      n_total++; if (idle_fall_cyc - tx_cyc[t0] !== 3) $display("FAIL idle_drop: got %0d clk want 3", idle_fall_cyc - tx_cyc[t0]); else n_pass++;
      n_total++; if (bus_idle !== 1'b0) $display("FAIL idle_in_frame: got %b want 0", bus_idle); else n_pass++;
      wait_idle("two_end_idle");
   endtask

   task automatic test_crc();
      int n0;
      n0 = dq.size();
      n_total++; if (crc_data !== 16'hFFFF) $display("FAIL crc_reinit: got %h want ffff", crc_data); else n_pass++;
      for (int i = 0; i < 9; i++) send_byte(8'(8'h31 + i), (i == 0) ? 10 : 4, 1'b1);
      send_byte(8'h37, 4, 1'b1);
      send_byte(8'h4B, 4, 1'b1);
      repeat (5) @(negedge clk);
      n_total++;
      if (dq.size() - n0 !== 11) $display("FAIL crc_count: %0d strobes, want 11", dq.size() - n0);
      else begin
         n_pass++;
         n_total++; if (cq[n0+8] !== 16'h4B37) $display("FAIL crc_check: got %h want 4b37", cq[n0+8]); else n_pass++;
         n_total++; if (cq[n0+10] !== 16'h0000) $display("FAIL crc_residue: got %h want 0000", cq[n0+10]); else n_pass++;
         n_total++; if (dq[n0+4] !== 8'h35) $display("FAIL crc_byte4: got %h want 35", dq[n0+4]); else n_pass++;
      end
      wait_idle("crc_end_idle");
   endtask

   task automatic test_frame_error();
      int n0, e0;
      n0 = dq.size();
      e0 = err_cnt;
      send_byte(8'h11, 10, 1'b1);
      send_byte(8'h22, 4, 1'b0);
      send_byte(8'h00, 4, 1'b1);
      repeat (97) @(negedge clk);
      n_total++; if (bus_idle !== 1'b0) $display("FAIL err_idle_early: got %b want 0", bus_idle); else n_pass++;
      @(negedge clk);
      n_total++; if (bus_idle !== 1'b1) $display("FAIL err_idle_at_100: got %b want 1", bus_idle); else n_pass++;
      n_total++; if (err_cnt - e0 !== 1) $display("FAIL err_pulses: got %0d want 1", err_cnt - e0); else n_pass++;
      n_total++; if (dq.size() - n0 !== 1) $display("FAIL err_strobes: got %0d want 1", dq.size() - n0); else n_pass++;
      n_total++; if (data !== 8'h11) $display("FAIL err_data: got %h want 11", data); else n_pass++;
      n_total++; if (crc_data !== 16'hFFFF) $display("FAIL err_crc_reinit: got %h want ffff", crc_data); else n_pass++;
   endtask

   task automatic test_glitch();
      int n0, e0;
      n0 = dq.size();
      e0 = err_cnt;
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      n_total++; if (dq.size() - n0 !== 0) $display("FAIL glitch_strobe: got %0d want 0", dq.size() - n0); else n_pass++;
      n_total++; if (bus_idle !== 1'b1) $display("FAIL glitch_idle: got %b want 1", bus_idle); else n_pass++;
      n_total++; if (err_cnt - e0 !== 0) $display("FAIL glitch_error: got %0d want 0", err_cnt - e0); else n_pass++;
   endtask

   task automatic test_wait_bus_idle();
      int n0;
      wait_bus_idle = 1'b1;
      @(negedge clk);
      wait_bus_idle = 1'b0;
      repeat (3) @(negedge clk);
      n_total++; if (bus_idle !== 1'b1) $display("FAIL wait_when_idle: bus_idle=%b want 1", bus_idle); else n_pass++;
      n0 = dq.size();
      send_byte(8'h01, 10, 1'b1);
      send_byte(8'h02, 4, 1'b1);
      fork
         send_byte(8'h03, 4, 1'b1);
         begin
            repeat (15) @(negedge clk);
            wait_bus_idle = 1'b1;
            @(negedge clk);
            wait_bus_idle = 1'b0;
         end
      join
      send_byte(8'h04, 4, 1'b1);
      repeat (10) @(negedge clk);
      n_total++; if (dq.size() - n0 !== 2) $display("FAIL wait_strobes: got %0d want 2", dq.size() - n0); else n_pass++;
      n_total++; if (data !== 8'h02) $display("FAIL wait_data: got %h want 02", data); else n_pass++;
      n_total++; if (bus_idle !== 1'b0) $display("FAIL wait_not_idle_yet: got %b want 0", bus_idle); else n_pass++;
      wait_idle("wait_end_idle");
   endtask

   initial begin
      reset_n = 1'b0;
      rx = 1'b1;
      div_ls = 16'd9;
      div_hs = 16'd3;
      wait_bus_idle = 1'b0;
      @(negedge clk);
      test_reset();
      test_two_bytes();
      test_crc();
      test_frame_error();
      test_glitch();
      test_wait_bus_idle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rx_ser.md
Name: rx_ser

Overview:
- Serial front end of the CDBUS receive path; sits directly upstream of the byte-level frame receiver.
- Synchronises the rx line and recovers UART-style bytes (1 start, 8 data LSB-first, 1 stop).
- Runs a CRC-16/MODBUS in parallel and detects bus idle.
- Presents each byte with a one-cycle strobe, plus the running CRC and a bus-idle level. The first byte of a frame is received at the low (arbitration) rate; all later bytes use the high rate.

Parameters:
- DIV_W, 16, width of baud divisor inputs
- IDLE_LEN, 10, rx-high bit periods (at low rate) that declare bus idle

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- rx  input  1  raw bus receive line, asynchronous
- div_ls  input  DIV_W  low-rate bit period minus 1 in clk cycles; legal values ≥ 3
- div_hs  input  DIV_W  high-rate bit period minus 1 in clk cycles; legal values ≥ 3
- wait_bus_idle  input  1  pulse: abandon current byte/frame, ignore bus until idle
- bus_idle  output  1  level: bus idle, no frame in progress
- data  output  8  last received byte
- crc_data  output  16  CRC over all frame bytes up to and including data
- data_clk  output  1  one-cycle strobe: data/crc_data updated
- error  output  1  one-cycle pulse: stop bit sampled low (framing error)

Behaviour:
- Reset values: bus_idle 0, data 0x00, crc_data 0xFFFF, data_clk 0, error 0, state WAIT_IDLE.
- rx passes through a 2-FF synchroniser, reset to 1. All edge and sample decisions use the synchronised value. Start-edge latency is 2 clk.
- Rate selection: byte 0 of a frame uses div_ls; bytes ≥ 1 use div_hs. Idle timing always uses div_ls.
- States:
  - WAIT_IDLE: no start detection.
  - HUNT: waiting for a falling edge.
  - START, DATA, STOP: byte reception.
- WAIT_IDLE:
  - Idle counter runs while rx=1; any rx=0 clears it.
  - After IDLE_LEN full periods of (div_ls+1) clk: set bus_idle=1, crc_data=0xFFFF, byte index 0, go to HUNT.
- HUNT:
  - Falling edge → clear bus_idle, go to START with phase counter = div/2 (integer).
  - If bus_idle=0, the idle counter also runs here. On expiry, bus_idle=1, crc reinitialised, byte index 0. This is the normal end of frame.
- START:
  - At half-bit, sample rx. If 0, enter DATA with a full-period counter.
  - If 1 (glitch), return to HUNT. bus_idle stays as before the glitch: restore 1 if it was idle.
- DATA:
  - Sample every div+1 clk, shifting LSB-first.
  - Each sampled bit also updates the shadow CRC: reflected poly 0xA001. crc = (crc>>1) ^ (lsb(crc)^bit ? 0xA001 : 0).
- STOP:
  - Sample at mid stop bit.
  - If 1: next cycle data_clk=1, data=byte, crc_data=shadow CRC; byte index increments (saturates); go to HUNT.
  - If 0: error=1 for 1 cycle, no data_clk, go to WAIT_IDLE.
- data and crc_data hold until the next data_clk or frame reinit. Appending the two CRC bytes (low first) yields crc_data=0x0000.
- wait_bus_idle:
  - If bus_idle=1, ignored.
  - Otherwise, from the next cycle: drop any partial byte, suppress data_clk, go to WAIT_IDLE with the idle counter cleared.
  - If it coincides with a stop-bit sample, wait_bus_idle wins and no strobe is issued.
- Divisor changes take effect at the next bit period.
- Asynchronous reset mid-byte: all state returns to reset values; the bus must then be seen idle again before any byte is accepted.

Decomposition:
- Package cdbus_pkg holds:
  - CRC16_POLY = 16'hA001 and CRC16_INIT = 16'hFFFF
  - state encodings (WAIT_IDLE, HUNT, START, DATA, STOP)
- Sub-module crc16_serial: bit-serial CRC register with inputs clr, en, bit and output crc[15:0]. It is instantiated once for the shadow CRC.

Test Plan:
- Reset, rx held 1, div_ls=9 → bus_idle rises exactly 100 clk (IDLE_LEN × 10) after the synchroniser output settles; no data_clk.
- Idle bus, div_ls=9, div_hs=3, send bytes 0x55 then 0xA3 → two data_clk pulses with data=0x55 and data=0xA3; bit timing checked at 10 clk and 4 clk per bit; bus_idle=0 from the start edge.
- Frame "123456789" (ASCII) followed by 0x37, 0x4B → crc_data after the 9th byte = 0x4B37; after the 11th byte = 0x0000.
- Stop bit forced 0 on the 2nd byte → error pulse, no data_clk for that byte, further bytes ignored until 100 clk of rx high, then bus_idle=1.
- 2-clk low glitch on an idle bus with div_ls=9 → no data_clk, bus_idle stays 1.
- wait_bus_idle pulsed mid-byte 3 → no strobe for byte 3, subsequent bytes ignored, bus_idle after idle timeout. Also pulse it while bus_idle=1 → no effect.
